miriscv_data_axil_bridge: RTL

Bridges the core's data memory port (the req/we/be/addr/wdata/rvalid/rdata interface driven by the load-store unit) onto an AXI4-Lite master. It sits directly downstream of the LSU. Stores are posted into a small write buffer so they complete in one core cycle. Loads are issued only after all earlier stores have been acknowledged, and data returns to the LSU with a single-cycle `data_rvalid_o` pulse.

---
 rtl/miriscv_data_axil_bridge.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/miriscv_data_axil_bridge.sv
// LSU data port to AXI4-Lite master bridge with a posted write buffer.
// Ports: clk_i/rst_i; data_* LSU side; m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite master.
module miriscv_data_axil_bridge #(
    parameter int unsigned WBUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_stall_o,
    output logic        wbuf_empty_o,
    output logic        bus_err_o,
    output logic [31:0] m_awaddr_o,
    output logic [2:0]  m_awprot_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    input  logic [1:0]  m_bresp_i,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    output logic [31:0] m_araddr_o,
    output logic [2:0]  m_arprot_o,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic        m_rvalid_i,
    output logic        m_rready_o
);

    localparam int unsigned PW = $clog2(WBUF_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(WBUF_DEPTH);

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } w_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_DRAIN,
        R_ADDR,
        R_DATA,
        R_DONE
    } r_state_t;

    logic [31:0]   buf_addr [WBUF_DEPTH];
    logic [31:0]   buf_data [WBUF_DEPTH];
    logic [3:0]    buf_be   [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          enq;
    logic          deq;
    logic          wbuf_empty;

    w_state_t      w_state;
    w_state_t      w_state_n;
    logic          load_head;
    logic          aw_pend;
    logic          w_pend;
    logic          aw_hs;
    logic          w_hs;
    logic [31:0]   awaddr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;

    r_state_t      r_state;
    r_state_t      r_state_n;
    logic [31:0]   araddr_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    // Full uses the registered count so a same-cycle pop never unblocks.
    assign full         = (count == FULL_CNT);
    assign enq          = data_req_i & data_we_i & ~full;
    assign data_stall_o = data_req_i & data_we_i & full;
    assign wbuf_empty   = (count == '0) & (w_state == W_IDLE);
    assign wbuf_empty_o = wbuf_empty;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            buf_addr[wr_ptr] <= data_addr_i;
            buf_data[wr_ptr] <= data_wdata_i;
            buf_be[wr_ptr]   <= data_be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq & ~deq) begin
                count <= count + (PW+1)'(1);
            end else if (deq & ~enq) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    assign aw_hs = aw_pend & m_awready_i;
    assign w_hs  = w_pend & m_wready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        load_head = 1'b0;
        deq       = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (count != '0) begin
                    load_head = 1'b1;
                    w_state_n = W_SEND;
                end
            end
            W_SEND: begin
                // AW and W complete independently; pop once both are done.
                if ((~aw_pend | aw_hs) & (~w_pend | w_hs)) begin
                    deq       = 1'b1;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: begin
                if (m_bvalid_i) begin
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (load_head) begin
            aw_pend  <= 1'b1;
            w_pend   <= 1'b1;
            awaddr_q <= buf_addr[rd_ptr];
            wdata_q  <= buf_data[rd_ptr];
            wstrb_q  <= buf_be[rd_ptr];
        end else begin
            if (aw_hs) begin
                aw_pend <= 1'b0;
            end
            if (w_hs) begin
                w_pend <= 1'b0;
            end
        end
    end

    assign m_awaddr_o  = awaddr_q;
    assign m_awprot_o  = 3'b000;
    assign m_awvalid_o = aw_pend;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;
    assign m_wvalid_o  = w_pend;
    assign m_bready_o  = (w_state == W_RESP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_n;
        end
    end

    always_comb begin
        r_state_n = r_state;
        unique case (r_state)
            R_IDLE: begin
                if (data_req_i & ~data_we_i) begin
                    r_state_n = R_DRAIN;
                end
            end
            R_DRAIN: begin
                // Loads wait for every earlier store to be acknowledged.
                if (wbuf_empty) begin
                    r_state_n = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_arready_i) begin
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (m_rvalid_i) begin
                    r_state_n = R_DONE;
                end
            end
            R_DONE:  r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            araddr_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((r_state == R_DRAIN) & wbuf_empty) begin
                araddr_q <= data_addr_i;
            end
            if ((r_state == R_DATA) & m_rvalid_i) begin
                rdata_q <= m_rdata_i;
            end
            err_q <= ((w_state == W_RESP) & m_bvalid_i & (|m_bresp_i))
                   | ((r_state == R_DATA) & m_rvalid_i & (|m_rresp_i));
        end
    end

    assign m_araddr_o    = araddr_q;
    assign m_arprot_o    = 3'b000;
    assign m_arvalid_o   = (r_state == R_ADDR);
    assign m_rready_o    = (r_state == R_DATA);
    assign data_rvalid_o = (r_state == R_DONE);
    assign data_rdata_o  = rdata_q;
    assign bus_err_o     = err_q;

endmodule
